uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DATA_W, default 8, width of each received byte.
REQ-002 Parameter: DEPTH, default 16, number of FIFO entries; power of two, minimum 2.
REQ-003 Port: clk  input  1  single clock for all logic, rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: uart_rdy  input  1  receiver byte-ready flag from the UART top; level, held until cleared.
REQ-006 Port: uart_data  input  DATA_W  received byte from the UART top; valid while uart_rdy=1.
REQ-007 Port: uart_rdy_clr  output  1  one-cycle pulse clearing the UART ready flag.
REQ-008 Port: rd_en  input  1  consumer read request.
REQ-009 Port: rd_data  output  DATA_W  registered read data.
REQ-010 Port: rd_valid  output  1  one-cycle pulse; rd_data is new this cycle.
REQ-011 Port: empty  output  1  FIFO holds no bytes.
REQ-012 Port: full  output  1  FIFO holds DEPTH bytes.
REQ-013 Port: count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 Port: overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-015 Port: ovr_clr  input  1  clears overrun.

Function
REQ-016 Capture FSM states: IDLE, CLR, WAIT_LOW.
REQ-017 IDLE and uart_rdy=1: the block samples uart_data, writes it if !full, and moves to CLR.
REQ-018 CLR: uart_rdy_clr=1 for exactly one cycle, then the FSM moves to WAIT_LOW.
REQ-019 WAIT_LOW: the FSM returns to IDLE on the first cycle uart_rdy=0; no further capture happens until then, so each byte is written once.
REQ-020 Latency: uart_rdy rising to word visible (empty=0) is 1 cycle; to uart_rdy_clr pulse is 1 cycle.
REQ-021 Capture while full: the byte is dropped, overrun sets on the next edge, and uart_rdy_clr still pulses.
REQ-022 Read: when rd_en=1 and empty=0, the head is loaded into rd_data at the edge and rd_valid pulses the next cycle.
REQ-023 rd_en while empty is ignored; rd_data holds its value and rd_valid stays 0.
REQ-024 Simultaneous write and read, not empty: both occur and count is unchanged.
REQ-025 Simultaneous write and read, full: the read frees a slot, the write is accepted, overrun does not set, and count stays DEPTH.
REQ-026 Simultaneous write and read, empty: the read is ignored, the write is accepted, and count becomes 1.
REQ-027 Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full and empty derive from count.
REQ-028 overrun: set has priority over ovr_clr in the same cycle.
REQ-029 All outputs are registered except empty and full, which decode combinationally from count.

Reset
REQ-030 reset_n=0 asynchronously forces: FSM=IDLE, pointers=0, count=0, empty=1, full=0, rd_data=0, rd_valid=0, uart_rdy_clr=0, overrun=0.
REQ-031 Reset mid-capture or mid-read discards the FIFO contents; storage array contents need not reset.
REQ-032 After release: if uart_rdy is already 1, it is captured normally from IDLE.

Configuration
REQ-033 Macro UART_RX_FIFO_OVR_CNT_EN: when defined, an extra output ovr_cnt [7:0] counts dropped bytes, saturating at 255, cleared by ovr_clr and by reset.
REQ-034 Without UART_RX_FIFO_OVR_CNT_EN: no ovr_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-035 Single byte: uart_rdy=1, uart_data=A5 -> one uart_rdy_clr pulse; empty=0, count=1; rd_en -> rd_data=A5, rd_valid pulse, empty=1.
REQ-036 Fill: 16 bytes 00..0F -> full=1, count=16; 17th byte 55 -> dropped, overrun=1, ovr_cnt=1 (macro on); drain -> 00..0F in order.
REQ-037 Wrap: write 10, read 10, write 16 bytes, read all -> data in order, count returns to 0.
REQ-038 Concurrency: full FIFO, rd_en with capture of 77 the same cycle -> count=16, overrun=0, 77 last out.
REQ-039 uart_rdy held high for 20 cycles after clr -> exactly one write, count=1.
REQ-040 reset_n low with count=5 and the FSM in CLR -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes from a level-style UART receiver ready flag
// into a synchronous FIFO and serves them to a consumer through a registered
// read port.
//
// Optional feature macro: UART_RX_FIFO_OVR_CNT_EN
//   When defined, adds output ovr_cnt[7:0], a saturating count of bytes
//   dropped because the FIFO was full (cleared by ovr_clr and reset).
//
// Ports:
//   clk          rising-edge clock for all logic
//   reset_n      asynchronous active-low reset
//   uart_rdy     receiver byte-ready level from the UART, held until cleared
//   uart_data    received byte, valid while uart_rdy=1
//   uart_rdy_clr one-cycle pulse that clears the UART ready flag
//   rd_en        consumer read request
//   rd_data      registered read data
//   rd_valid     one-cycle pulse, rd_data is new this cycle
//   empty/full   occupancy decodes of count (combinational)
//   count        current occupancy, 0..DEPTH
//   overrun      sticky: a byte was dropped while full
//   ovr_clr      clears overrun (a same-cycle drop wins)
//   ovr_cnt      (macro only) saturating dropped-byte counter
//
// DEPTH must be a power of two, minimum 2.

module uart_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       uart_rdy,
  input  logic [DATA_W-1:0]          uart_data,
  output logic                       uart_rdy_clr,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overrun,
  input  logic                       ovr_clr
`ifdef UART_RX_FIFO_OVR_CNT_EN
  ,
  output logic [7:0]                 ovr_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                capture;
  logic                rd_do;
  logic                wr_do;
  logic                drop;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                rdy_clr_q;
  logic                overrun_q;

  // Capture FSM: one capture per assertion of uart_rdy.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (uart_rdy) begin
          capture = 1'b1;
          state_d = CLR;
        end
      end
      CLR:      state_d = WAIT_LOW;
      WAIT_LOW: if (!uart_rdy) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Occupancy decodes and transfer qualifiers.
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign rd_do = rd_en && !empty;
  // A same-cycle read frees a slot, so a capture into a full FIFO still lands.
  assign wr_do = capture && (!full || rd_do);
  assign drop  = capture && full && !rd_do;

  // State register; the clear pulse is registered off the IDLE->CLR transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rdy_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_clr_q <= (state_d == CLR) && (state_q != CLR);
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr_q] <= uart_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_do) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_do) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_do, rd_do})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered read port; a full-FIFO read+write sees the old head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_do;
      if (rd_do) rd_data_q <= mem[rd_ptr_q];
    end
  end

  // Sticky overrun; a drop outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (ovr_clr) begin
      overrun_q <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_OVR_CNT_EN
  logic [7:0] ovr_cnt_q;

  // Saturating drop counter; a drop coinciding with a clear restarts at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_cnt_q <= 8'd0;
    end else if (drop) begin
      if (ovr_clr)                 ovr_cnt_q <= 8'd1;
      else if (ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end else if (ovr_clr) begin
      ovr_cnt_q <= 8'd0;
    end
  end

  assign ovr_cnt = ovr_cnt_q;
`endif

  assign uart_rdy_clr = rdy_clr_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign overrun      = overrun_q;

endmodule
